eth_pcs_tx_scrambler: RTL and testbench

//  Self-synchronous 64b/66b TX scrambler using G(x)=1+x^39+x^58, one W_DATA-bit half-block per transfer.

---
 rtl/eth_pcs_tx_scrambler.sv | 83 ++++++++
 tb/tb_eth_pcs_tx_scrambler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_tx_scrambler.sv
// 64b/66b TX scrambler (G(x)=1+x^39+x^58), one half-block per gearbox accept.
// Registers scrambled payload and raw sync header and counts invalid headers.
module eth_pcs_tx_scrambler #(
   parameter int                 W_DATA          = 32,
   parameter int                 W_SYNC          = 2,
   parameter int                 W_TRANS_PER_BLK = 1,
   parameter int                 W_SCR           = 58,
   parameter logic [W_SCR-1:0]   SCR_SEED        = '1,
   parameter int                 W_ERR_CNT       = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_clk_en,
   input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
   input  logic                       i_bypass,
   input  logic [W_SYNC-1:0]          i_sync_hdr,
   input  logic [W_DATA-1:0]          i_data,
   output logic [W_SYNC-1:0]          o_sync_hdr,
   output logic [W_DATA-1:0]          o_scr_data,
   output logic                       o_hdr_err,
   output logic [W_ERR_CNT-1:0]       o_hdr_err_cnt
);

   localparam logic [W_TRANS_PER_BLK-1:0] LAST  = '1;
   localparam int                         TAP_A = 38;
   localparam int                         TAP_B = W_SCR - 1;

   logic [W_SCR-1:0]     r_state;
   logic [W_SYNC-1:0]    r_sync_hdr;
   logic [W_DATA-1:0]    r_scr_data;
   logic                 r_hdr_err;
   logic [W_ERR_CNT-1:0] r_hdr_err_cnt;

   logic [W_SCR-1:0]     w_state_nxt;
   logic [W_DATA-1:0]    w_scr;
   logic                 w_hdr_bad;
   logic                 w_last;

   // Serial scrambler unrolled over the whole word; bit 0 goes on the wire first.
   always_comb begin
      w_state_nxt = r_state;
      w_scr       = '0;
      for (int i = 0; i < W_DATA; i++) begin
         w_scr[i]    = i_data[i] ^ w_state_nxt[TAP_A] ^ w_state_nxt[TAP_B];
         w_state_nxt = {w_state_nxt[W_SCR-2:0], w_scr[i]};
      end
   end

   assign w_last    = (i_trans_cnt == LAST);
   assign w_hdr_bad = (i_sync_hdr == '0) || (i_sync_hdr == '1);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= SCR_SEED;
         r_sync_hdr    <= '0;
         r_scr_data    <= '0;
         r_hdr_err     <= 1'b0;
         r_hdr_err_cnt <= '0;
      end else begin
         r_hdr_err <= 1'b0;
         if (i_clk_en) begin
            // State follows the scrambled stream even in bypass, so leaving bypass needs no reseed.
            r_state    <= w_state_nxt;
            r_scr_data <= i_bypass ? i_data : w_scr;
            if (w_last) begin
               r_sync_hdr <= i_sync_hdr;
               if (w_hdr_bad) begin
                  r_hdr_err <= 1'b1;
                  if (r_hdr_err_cnt != '1) begin
                     r_hdr_err_cnt <= r_hdr_err_cnt + 1'b1;
                  end
               end
            end
         end
      end
   end

   assign o_sync_hdr    = r_sync_hdr;
   assign o_scr_data    = r_scr_data;
   assign o_hdr_err     = r_hdr_err;
   assign o_hdr_err_cnt = r_hdr_err_cnt;

endmodule

// File: tb/tb_eth_pcs_tx_scrambler.sv
// Bench for eth_pcs_tx_scrambler: randomized transfers against a bit-serial
// history model of the scrambler, plus header-check and reset scenarios.
module tb_eth_pcs_tx_scrambler;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic [0:0]  tc;
   logic        byp;
   logic [1:0]  hdr;
   logic [31:0] data;

   logic [1:0]  o_hdr,  o_hdr0;
   logic [31:0] o_scr,  o_scr0;
   logic        o_err,  o_err0;
   logic [7:0]  o_cnt,  o_cnt0;

   int n_checks = 0;
   int n_errors = 0;

   // expected-value model: history of transmitted scrambled bits, newest first
   bit          mq[$];
   logic [31:0] e_data;
   logic [1:0]  e_hdr;
   logic        e_err;
   logic [7:0]  e_cnt;

   eth_pcs_tx_scrambler #(.SCR_SEED('1)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_clk_en(ce), .i_trans_cnt(tc),
      .i_bypass(byp), .i_sync_hdr(hdr), .i_data(data),
      .o_sync_hdr(o_hdr), .o_scr_data(o_scr), .o_hdr_err(o_err), .o_hdr_err_cnt(o_cnt));

   eth_pcs_tx_scrambler #(.SCR_SEED('0)) dut0 (
      .i_clk(clk), .i_reset(rst_n), .i_clk_en(ce), .i_trans_cnt(tc),
      .i_bypass(byp), .i_sync_hdr(hdr), .i_data(data),
      .o_sync_hdr(o_hdr0), .o_scr_data(o_scr0), .o_hdr_err(o_err0), .o_hdr_err_cnt(o_cnt0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < 58; i++) mq.push_back(1'b1);
      e_data = '0;
      e_hdr  = '0;
      e_err  = 1'b0;
      e_cnt  = '0;
   endtask

   // Drive one cycle of stimulus, advance the model, and return 1 ns after the edge.
   task automatic xfer(input logic c, input logic [0:0] t, input logic b,
                       input logic [1:0] h, input logic [31:0] d);
      bit s;
      ce = c; tc = t; byp = b; hdr = h; data = d;
      e_err = 1'b0;
      if (c) begin
         for (int i = 0; i < 32; i++) begin
            s = d[i] ^ mq[38] ^ mq[57];
            mq.push_front(s);
            void'(mq.pop_back());
            e_data[i] = b ? d[i] : s;
         end
         if (t == 1'b1) begin
            e_hdr = h;
            if (h == 2'b00 || h == 2'b11) begin
               e_err = 1'b1;
               if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ce = 1'b0; tc = '0; byp = 1'b0; hdr = 2'b01; data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (o_scr !== 32'h0 || o_hdr !== 2'b00 || o_err !== 1'b0 || o_cnt !== 8'h00) begin
         n_errors++;
         $display("FAIL reset: scr=%h hdr=%b err=%b cnt=%h required all zero", o_scr, o_hdr, o_err, o_cnt);
      end
      n_checks++;
      if (o_scr0 !== 32'h0 || o_hdr0 !== 2'b00 || o_cnt0 !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_seed0: scr=%h hdr=%b cnt=%h required all zero", o_scr0, o_hdr0, o_cnt0);
      end
   endtask

   task automatic test_zero_seed();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         xfer(1'b1, k[0] ? 1'b0 : 1'b1, 1'b0, 2'b10, 32'h0);
         n_checks++;
         if (o_scr0 !== 32'h0 || o_hdr0 !== 2'b10 || o_err0 !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_seed[%0d]: scr=%h hdr=%b err=%b required scr=0 hdr=10 err=0", k, o_scr0, o_hdr0, o_err0);
         end
      end
   endtask

   task automatic test_bypass_hold();
      do_reset();
      xfer(1'b1, 1'b1, 1'b0, 2'b01, $urandom);
      xfer(1'b1, 1'b0, 1'b1, 2'b10, 32'hDEADBEEF);
      n_checks++;
      if (o_scr !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL bypass: scr=%h required DEADBEEF", o_scr);
      end
      for (int k = 0; k < 3; k++) begin
         xfer(1'b0, 1'b1, 1'b0, 2'b11, $urandom);
         n_checks++;
         if (o_scr !== 32'hDEADBEEF || o_hdr !== 2'b01 || o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL hold[%0d]: scr=%h hdr=%b err=%b required DEADBEEF/01/0", k, o_scr, o_hdr, o_err);
         end
      end
      // state advanced through bypass: next scrambled word must still follow the model
      xfer(1'b1, 1'b1, 1'b0, 2'b10, $urandom);
      n_checks++;
      if (o_scr !== e_data) begin
         n_errors++;
         $display("FAIL after_bypass: scr=%h required %h", o_scr, e_data);
      end
   endtask

   task automatic test_random();
      bit          rq[$];
      logic [0:0]  t;
      logic        c, b, rb;
      logic [1:0]  h;
      logic [31:0] d, rec;
      int          words;
      do_reset();
      for (int i = 0; i < 58; i++) rq.push_back(1'b0);
      t = 1'b1;
      words = 0;
      for (int n = 0; n < 2300 && words < 2000; n++) begin
         c = ($urandom_range(0, 16) != 0);
         b = 1'b0;
         case ($urandom_range(0, 9))
            0:       h = 2'b00;
            1:       h = 2'b11;
            2, 3, 4: h = 2'b01;
            default: h = 2'b10;
         endcase
         d = $urandom;
         xfer(c, t, b, h, d);
         n_checks++;
         if (o_scr !== e_data || o_hdr !== e_hdr || o_err !== e_err || o_cnt !== e_cnt) begin
            n_errors++;
            $display("FAIL random[%0d]: scr=%h hdr=%b err=%b cnt=%h required %h %b %b %h",
                     n, o_scr, o_hdr, o_err, o_cnt, e_data, e_hdr, e_err, e_cnt);
         end
         if (c) begin
            for (int i = 0; i < 32; i++) begin
               rb = o_scr[i];
               rec[i] = rb ^ rq[38] ^ rq[57];
               rq.push_front(rb);
               void'(rq.pop_back());
            end
            if (words >= 2) begin
               n_checks++;
               if (rec !== d) begin
                  n_errors++;
                  $display("FAIL descramble[%0d]: got %h required %h", words, rec, d);
               end
            end
            words++;
            t = ~t;
         end
      end
   endtask

   task automatic test_hdr_err();
      do_reset();
      xfer(1'b1, 1'b1, 1'b0, 2'b11, $urandom);
      n_checks++;
      if (o_err !== 1'b1 || o_cnt !== 8'd1 || o_hdr !== 2'b11) begin
         n_errors++;
         $display("FAIL hdr_err_first: err=%b cnt=%h hdr=%b required 1/01/11", o_err, o_cnt, o_hdr);
      end
      xfer(1'b1, 1'b0, 1'b0, 2'b01, $urandom);
      n_checks++;
      if (o_err !== 1'b0 || o_cnt !== 8'd1) begin
         n_errors++;
         $display("FAIL hdr_err_pulse: err=%b cnt=%h required 0/01", o_err, o_cnt);
      end
      for (int k = 0; k < 299; k++) begin
         xfer(1'b1, 1'b1, 1'b0, k[0] ? 2'b00 : 2'b11, $urandom);
         n_checks++;
         if (o_err !== 1'b1 || o_cnt !== e_cnt) begin
            n_errors++;
            $display("FAIL hdr_err_sat[%0d]: err=%b cnt=%h required 1/%h", k, o_err, o_cnt, e_cnt);
         end
      end
      n_checks++;
      if (o_cnt !== 8'hFF) begin
         n_errors++;
         $display("FAIL hdr_err_final: cnt=%h required FF", o_cnt);
      end
   endtask

   task automatic test_non_last();
      do_reset();
      xfer(1'b1, 1'b1, 1'b0, 2'b10, $urandom);
      for (int k = 0; k < 4; k++) begin
         xfer(1'b1, 1'b0, 1'b0, k[0] ? 2'b00 : 2'b11, $urandom);
         n_checks++;
         if (o_hdr !== 2'b10 || o_err !== 1'b0 || o_cnt !== 8'h00 || o_scr !== e_data) begin
            n_errors++;
            $display("FAIL non_last[%0d]: hdr=%b err=%b cnt=%h scr=%h required 10/0/00/%h",
                     k, o_hdr, o_err, o_cnt, o_scr, e_data);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [0:0] t;
      do_reset();
      xfer(1'b1, 1'b1, 1'b0, 2'b00, $urandom);
      xfer(1'b1, 1'b0, 1'b0, 2'b01, $urandom);
      xfer(1'b1, 1'b1, 1'b0, 2'b10, $urandom);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_scr !== 32'h0 || o_hdr !== 2'b00 || o_err !== 1'b0 || o_cnt !== 8'h00) begin
         n_errors++;
         $display("FAIL async_reset: scr=%h hdr=%b err=%b cnt=%h required all zero", o_scr, o_hdr, o_err, o_cnt);
      end
      model_reset();
      ce = 1'b1; data = $urandom;
      @(posedge clk); #1;
      n_checks++;
      if (o_scr !== 32'h0) begin
         n_errors++;
         $display("FAIL async_reset_hold: scr=%h required 0", o_scr);
      end
      rst_n = 1'b1;
      t = 1'b0;
      for (int k = 0; k < 40; k++) begin
         xfer(1'b1, t, ($urandom_range(0, 7) == 0), 2'b01, $urandom);
         t = ~t;
         n_checks++;
         if (o_scr !== e_data || o_hdr !== e_hdr) begin
            n_errors++;
            $display("FAIL post_reset[%0d]: scr=%h hdr=%b required %h %b", k, o_scr, o_hdr, e_data, e_hdr);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ce = 1'b0; tc = '0; byp = 1'b0; hdr = 2'b01; data = '0;
      model_reset();
      test_reset();
      test_zero_seed();
      test_bypass_hold();
      test_random();
      test_hdr_err();
      test_non_last();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
